// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM (1-cycle registered
// read, read-first) between two requesters A and B.
//
// After reset (when CLR_ON_RESET=1) and on every clr pulse the block sweeps the
// whole RAM to INIT_VAL, one word per cycle, with busy high. Otherwise it
// grants at most one access per cycle, round-robin between A and B, and
// returns read data to the port that issued the read.
//
// Handshake (both ports): a transfer happens on a cycle where x_req and x_gnt
// are both high. x_gnt is combinational and only ever asserted together with
// x_req. The requester holds x_req/x_we/x_addr/x_din stable until it sees
// x_gnt, and may drop x_req without having been granted. Read data follows on
// the next cycle, marked by x_rvalid (one cycle, no backpressure).
module ram_port_arbiter #(
    parameter int            DW           = 8,
    parameter int            AW           = 8,
    parameter logic [DW-1:0] INIT_VAL     = '0,
    parameter bit            CLR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_qout,

    // Current FSM state: 1 = clear sweep, 0 = arbitration.
    output logic          dbg_state
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t        RST_STATE = CLR_ON_RESET ? ST_CLEAR : ST_ARB;
    localparam logic [AW-1:0] CNT_LAST  = '1;
    localparam logic [AW-1:0] CNT_ONE   = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] cnt;
    // 1 when B held the most recent grant, so A wins the next tie.
    logic          last_b;

    assign busy      = (state == ST_CLEAR);
    assign dbg_state = state;

    // Read data is shared; each port's rvalid says whose data it is.
    assign a_rdata = ram_qout;
    assign b_rdata = ram_qout;

    // Round-robin grant: a lone requester wins, a tie goes to the port
    // that was not granted last. No grants during the sweep or on clr.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state == ST_ARB && !clr) begin
            if (a_req && b_req) begin
                a_gnt = last_b;
                b_gnt = !last_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // RAM port mux: sweep writes, otherwise the granted port, otherwise idle zeros.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (state == ST_CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = cnt;
            ram_din  = INIT_VAL;
        end else if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_din;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_din;
        end
    end

    // Sweep/arbitration FSM, round-robin history and read-return flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            cnt      <= '0;
            last_b   <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            // A write cycle's qout is old data and is never flagged valid.
            a_rvalid <= a_gnt & a_req & ~a_we;
            b_rvalid <= b_gnt & b_req & ~b_we;
            case (state)
                ST_CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_ARB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_ARB: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end else if (a_gnt) begin
                        last_b <= 1'b0;
                    end else if (b_gnt) begin
                        last_b <= 1'b1;
                    end
                end
                default: begin
                    state <= RST_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM on the RAM ports, directed
// scenarios followed by random dual-port traffic with clr pulses, and a
// negedge monitor that checks every output against a reference model.
module tb_ram_port_arbiter;

    localparam int            DW       = 8;
    localparam int            AW       = 4;
    localparam int            DEPTH    = 1 << AW;
    localparam logic [DW-1:0] INIT_VAL = 8'h5A;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          busy;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din, b_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_qout;
    logic          dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    ram_port_arbiter #(
        .DW(DW), .AW(AW), .INIT_VAL(INIT_VAL), .CLR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_qout(ram_qout), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural single-port RAM, registered read-first output.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_qout <= ram_mem[ram_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] exp_mem [DEPTH];   // what each RAM word should hold
    logic [DW-1:0] exp_q_a[$];        // expected read data, port A
    logic [DW-1:0] exp_q_b[$];        // expected read data, port B
    bit            m_clear  = 1'b1;   // sweep in progress
    int            m_cnt    = 0;      // next word the sweep writes
    bit            m_last_b = 1'b1;   // B was the last port served
    bit            m_pend_a = 1'b0;   // a read for A lands this cycle
    bit            m_pend_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          e_ag, e_bg, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din, e_rd;

        if (!rst_n) begin
            m_clear  = 1'b1;
            m_cnt    = 0;
            m_last_b = 1'b1;
            m_pend_a = 1'b0;
            m_pend_b = 1'b0;
            exp_q_a.delete();
            exp_q_b.delete();
        end

        // Who should be served this cycle.
        e_ag = 1'b0;
        e_bg = 1'b0;
        if (!m_clear && !clr) begin
            if (a_req && b_req) begin
                if (m_last_b) e_ag = 1'b1;
                else          e_bg = 1'b1;
            end else begin
                e_ag = a_req;
                e_bg = b_req;
            end
        end

        // What the RAM should see this cycle.
        e_we = 1'b0; e_addr = '0; e_din = '0;
        if (m_clear) begin
            e_we = 1'b1; e_addr = AW'(m_cnt); e_din = INIT_VAL;
        end else if (e_ag) begin
            e_we = a_we; e_addr = a_addr; e_din = a_din;
        end else if (e_bg) begin
            e_we = b_we; e_addr = b_addr; e_din = b_din;
        end

        check("busy",      32'(busy),      32'(m_clear));
        check("dbg_state", 32'(dbg_state), 32'(m_clear));
        check("a_gnt",     32'(a_gnt),     32'(e_ag));
        check("b_gnt",     32'(b_gnt),     32'(e_bg));
        check("ram_we",    32'(ram_we),    32'(e_we));
        check("ram_addr",  32'(ram_addr),  32'(e_addr));
        check("ram_din",   32'(ram_din),   32'(e_din));
        check("a_rvalid",  32'(a_rvalid),  32'(m_pend_a));
        check("b_rvalid",  32'(b_rvalid),  32'(m_pend_b));

        if (m_pend_a) begin
            if (exp_q_a.size() == 0) check("a_queue_underflow", 32'd1, 32'd0);
            else begin
                e_rd = exp_q_a.pop_front();
                check("a_rdata", 32'(a_rdata), 32'(e_rd));
            end
        end
        if (m_pend_b) begin
            if (exp_q_b.size() == 0) check("b_queue_underflow", 32'd1, 32'd0);
            else begin
                e_rd = exp_q_b.pop_front();
                check("b_rdata", 32'(b_rdata), 32'(e_rd));
            end
        end

        // Advance the model across the coming rising edge.
        if (rst_n) begin
            if (m_clear) begin
                exp_mem[m_cnt] = INIT_VAL;
                m_pend_a = 1'b0;
                m_pend_b = 1'b0;
                if (clr)                   m_cnt = 0;
                else if (m_cnt == DEPTH-1) begin m_clear = 1'b0; m_cnt = 0; end
                else                       m_cnt++;
            end else begin
                m_pend_a = e_ag && !a_we;
                m_pend_b = e_bg && !b_we;
                if (e_ag) begin
                    if (a_we) exp_mem[a_addr] = a_din;
                    else      exp_q_a.push_back(exp_mem[a_addr]);
                    m_last_b = 1'b0;
                end
                if (e_bg) begin
                    if (b_we) exp_mem[b_addr] = b_din;
                    else      exp_q_b.push_back(exp_mem[b_addr]);
                    m_last_b = 1'b1;
                end
                if (clr) begin
                    m_clear = 1'b1;
                    m_cnt   = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        int w;
        a_req = 1'b1; a_we = we; a_addr = addr; a_din = din;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (a_gnt) break;
        end
        if (w == 200) check("a_grant_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        a_req = 1'b0;
    endtask

    task automatic b_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        int w;
        b_req = 1'b1; b_we = we; b_addr = addr; b_din = din;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (b_gnt) break;
        end
        if (w == 200) check("b_grant_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    // Counts sweep cycles until busy drops; a full sweep is DEPTH cycles.
    task automatic wait_idle(input string name);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check(name, 32'(n), 32'(DEPTH));
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; clr = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        cyc(3);
        rst_n = 1'b1;

        // Power-on sweep, then B reads a cleared word.
        wait_idle("sweep_after_reset");
        b_access(1'b0, 4'd7, '0);

        // Simultaneous writes, then cross reads.
        fork
            a_access(1'b1, 4'd3, 8'h11);
            b_access(1'b1, 4'd9, 8'h22);
        join
        fork
            a_access(1'b0, 4'd9, '0);
            b_access(1'b0, 4'd3, '0);
        join

        // Continuous dual reads alternate A,B.
        fork
            repeat (4) a_access(1'b0, AW'($urandom_range(0, DEPTH-1)), '0);
            repeat (4) b_access(1'b0, AW'($urandom_range(0, DEPTH-1)), '0);
        join

        // Write then immediate read of the same word.
        a_access(1'b1, 4'd4, 8'hC3);
        a_access(1'b0, 4'd4, '0);

        // clr with A requesting and a B read in flight.
        b_access(1'b0, 4'd9, '0);
        fork
            a_access(1'b0, 4'd3, '0);
            pulse_clr();
        join
        cyc(2);

        // Restarted sweep: second clr ten cycles in.
        pulse_clr();
        cyc(10);
        pulse_clr();
        wait_idle("sweep_restart_by_clr");

        // Reset mid-sweep.
        pulse_clr();
        cyc(6);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        wait_idle("sweep_after_mid_reset");

        // Reset with a read in flight.
        b_access(1'b0, 4'd2, '0);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        wait_idle("sweep_after_read_reset");

        // Random traffic on both ports with occasional clr.
        fork
            for (int i = 0; i < 40; i++) begin
                cyc($urandom_range(0, 2));
                a_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
                         DW'($urandom_range(0, 255)));
            end
            for (int i = 0; i < 40; i++) begin
                cyc($urandom_range(0, 2));
                b_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
                         DW'($urandom_range(0, 255)));
            end
            for (int k = 0; k < 3; k++) begin
                cyc($urandom_range(20, 50));
                pulse_clr();
            end
        join

        // Read back every word through alternating ports.
        cyc(20);
        for (int i = 0; i < DEPTH; i += 2) begin
            fork
                a_access(1'b0, AW'(i), '0);
                b_access(1'b0, AW'(i + 1), '0);
            join
        end

        cyc(3);
        check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
